// File: rtl/reg_access_pkg.sv
// Shared types and command-byte layout for the register access sequencer.
package reg_access_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_DONE,
        RD_LOAD,
        RD_SEND,
        RD_ACK
    } state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_ADDR_W    = 7;

endpackage

// File: rtl/reg_access_timeout.sv
// Watchdog for write frames: reloads on i_load, counts down while enabled,
// flags expiry once TIMEOUT_CYCLES-1 idle cycles have elapsed.
module reg_access_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    assign o_expire = i_en && !i_load && (r_count == '0);

endmodule

// File: rtl/reg_access_ctrl.sv
// Byte-serial command sequencer: decodes UART command bytes into register
// bank byte writes, and streams register snapshots back to the transmitter.
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int DATA_BYTES     = 4,
    parameter int NUM_REGS       = 16,
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          tx_ready,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    output logic [ADDR_W-1:0]             reg_addr,
    output logic                          reg_write,
    output logic [7:0]                    reg_wdata,
    output logic [$clog2(DATA_BYTES)-1:0] reg_write_byte,
    output logic                          reg_write_done,
    output logic                          reg_read_ack,
    input  logic [8*DATA_BYTES-1:0]       reg_rdata,
    output logic                          busy,
    output logic                          err
);

    localparam int               CNT_W    = $clog2(DATA_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BYTES - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_addr_ok;
    logic [ADDR_W-1:0]       r_addr;
    logic [8*DATA_BYTES-1:0] r_snap;
    logic                    r_write;
    logic [7:0]              r_wdata;
    logic [CNT_W-1:0]        r_wbyte;
    logic                    r_write_done;
    logic                    r_read_ack;
    logic                    r_err;

    logic w_cmd_write;
    logic w_cmd_addr_ok;
    logic w_tx_fire;
    logic w_last;
    logic w_wd_load;
    logic w_wd_expire;

    assign w_cmd_write   = rx_data[CMD_WRITE_BIT];
    assign w_cmd_addr_ok = int'(rx_data[CMD_ADDR_W-1:0]) < NUM_REGS;
    assign w_tx_fire     = (r_state == RD_SEND) && tx_ready;
    assign w_last        = (r_cnt == LAST_IDX);
    assign w_wd_load     = rx_valid || (r_state != WR_DATA);

    reg_access_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_wd_load),
        .i_en     (r_state == WR_DATA),
        .o_expire (w_wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (w_cmd_write) begin
                        w_next = WR_DATA;
                    end else if (w_cmd_addr_ok) begin
                        w_next = RD_LOAD;
                    end
                end
            end
            WR_DATA: begin
                if (rx_valid && w_last) begin
                    w_next = WR_DONE;
                end else if (w_wd_expire) begin
                    w_next = IDLE;
                end
            end
            WR_DONE: w_next = IDLE;
            RD_LOAD: w_next = RD_SEND;
            RD_SEND: begin
                if (w_tx_fire && w_last) begin
                    w_next = RD_ACK;
                end
            end
            RD_ACK:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pulses default low each cycle; bytes outside a frame raise err.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_addr_ok    <= 1'b0;
            r_addr       <= '0;
            r_snap       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_wbyte      <= '0;
            r_write_done <= 1'b0;
            r_read_ack   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_write      <= 1'b0;
            r_write_done <= 1'b0;
            r_read_ack   <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        r_addr    <= ADDR_W'(rx_data[CMD_ADDR_W-1:0]);
                        r_addr_ok <= w_cmd_addr_ok;
                        r_cnt     <= '0;
                        r_err     <= !w_cmd_write && !w_cmd_addr_ok;
                    end
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        r_write <= r_addr_ok;
                        r_wdata <= rx_data;
                        r_wbyte <= r_cnt;
                        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    end else if (w_wd_expire) begin
                        r_err <= 1'b1;
                        r_cnt <= '0;
                    end
                end
                WR_DONE: begin
                    r_write_done <= r_addr_ok;
                    r_err        <= !r_addr_ok || rx_valid;
                end
                RD_LOAD: begin
                    r_snap <= reg_rdata;
                    r_err  <= rx_valid;
                end
                RD_SEND: begin
                    r_err <= rx_valid;
                    if (w_tx_fire) begin
                        r_snap     <= r_snap >> 8;
                        r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
                        r_read_ack <= w_last;
                    end
                end
                RD_ACK: begin
                    r_err <= rx_valid;
                end
                default: ;
            endcase
        end
    end

    assign tx_valid       = (r_state == RD_SEND);
    assign tx_data        = r_snap[7:0];
    assign reg_addr       = r_addr;
    assign reg_write      = r_write;
    assign reg_wdata      = r_wdata;
    assign reg_write_byte = r_wbyte;
    assign reg_write_done = r_write_done;
    assign reg_read_ack   = r_read_ack;
    assign busy           = (r_state != IDLE);
    assign err            = r_err;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Randomized transaction bench for reg_access_ctrl with a register bank model
// and expected event timing derived from the command protocol.
module tb_reg_access_ctrl;

    localparam int DB = 4;
    localparam int NR = 16;
    localparam int AW = 7;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [AW-1:0] reg_addr;
    logic          reg_write;
    logic [7:0]    reg_wdata;
    logic [1:0]    reg_write_byte;
    logic          reg_write_done;
    logic          reg_read_ack;
    logic [31:0]   reg_rdata;
    logic          busy;
    logic          err;

    logic [31:0] bank     [NR];
    logic [31:0] ref_bank [NR];
    logic        bank_init;
    logic        scr_req;
    logic [3:0]  scr_addr;
    logic [31:0] scr_val;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_tx    = '0;

    int          wr_cyc_q [$];
    logic [16:0] wr_val_q [$];
    int          done_q   [$];
    int          ack_q    [$];
    int          err_q    [$];
    logic [7:0]  tx_q     [$];
    int          tx_cyc_q [$];
    int          txv_q    [$];

    reg_access_ctrl #(
        .DATA_BYTES     (DB),
        .NUM_REGS       (NR),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .tx_ready       (tx_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .reg_addr       (reg_addr),
        .reg_write      (reg_write),
        .reg_wdata      (reg_wdata),
        .reg_write_byte (reg_write_byte),
        .reg_write_done (reg_write_done),
        .reg_read_ack   (reg_read_ack),
        .reg_rdata      (reg_rdata),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return {8'(i), 8'hA5, 8'(3 * i + 1), 8'h5A};
    endfunction

    // Register bank environment: applies DUT strobes, mutation requests.
    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < NR; i++) bank[i] <= init_val(i);
        end else if (scr_req) begin
            bank[scr_addr] <= scr_val;
        end else if (reg_write && (reg_addr < NR)) begin
            bank[reg_addr[3:0]][8*reg_write_byte +: 8] <= reg_wdata;
        end
    end

    always_comb reg_rdata = (reg_addr < NR) ? bank[reg_addr[3:0]] : 32'h0;

    always @(negedge clk) begin
        if (!reset) begin
            if (reg_write) begin
                wr_cyc_q.push_back(cyc);
                wr_val_q.push_back({reg_addr, reg_write_byte, reg_wdata});
            end
            if (reg_write_done) done_q.push_back(cyc);
            if (reg_read_ack)   ack_q.push_back(cyc);
            if (err)            err_q.push_back(cyc);
            if (tx_valid)       txv_q.push_back(cyc);
            if (tx_valid && tx_ready) begin
                tx_q.push_back(tx_data);
                tx_cyc_q.push_back(cyc);
            end
            if (prev_stall && tx_valid && (tx_data != prev_tx)) stall_viol <= stall_viol + 1;
            prev_stall <= tx_valid && !tx_ready;
            prev_tx    <= tx_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b, output int at);
        rx_valid = 1'b1;
        rx_data  = b;
        at       = cyc;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic clear_q();
        wr_cyc_q.delete(); wr_val_q.delete(); done_q.delete(); ack_q.delete();
        err_q.delete(); tx_q.delete(); tx_cyc_q.delete(); txv_q.delete();
    endtask

    // nb < DB leaves the frame incomplete so the watchdog must fire.
    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input int nb,
                            input int maxgap, input bit chain);
        int  t [DB];
        int  tc;
        int  tend;
        bit  ok;
        bit  exp_done;
        ok = (a < NR);
        clear_q();
        send({1'b1, a}, tc);
        chk("wr_busy", busy, 1);
        for (int i = 0; i < nb; i++) begin
            idle($urandom_range(0, maxgap));
            send(d[8*i +: 8], t[i]);
            if (ok) ref_bank[a[3:0]][8*i +: 8] = d[8*i +: 8];
        end
        tend = (nb == 0) ? tc : t[nb-1];
        if (chain)         idle(1);
        else if (nb == DB) idle(3);
        else               idle(TO + 4);
        chk("wr_count", wr_cyc_q.size(), ok ? nb : 0);
        for (int i = 0; i < wr_cyc_q.size() && i < nb; i++) begin
            chk("wr_cyc", wr_cyc_q[i], t[i] + 1);
            chk("wr_val", wr_val_q[i], {a, 2'(i), d[8*i +: 8]});
        end
        if (!chain) begin
            exp_done = ok && (nb == DB);
            chk("wr_done_n", done_q.size(), exp_done);
            if (exp_done && done_q.size() > 0) chk("wr_done_cyc", done_q[0], tend + 2);
            chk("wr_err_n", err_q.size(), exp_done ? 0 : 1);
            if (!exp_done && err_q.size() > 0)
                chk("wr_err_cyc", err_q[0], (nb == DB) ? tend + 2 : tend + TO + 1);
            chk("wr_idle", busy, 0);
        end
    endtask

    // mode 0: tx_ready held high, 1: random tx_ready, 2: long stall on byte 1
    // while the register changes underneath.
    task automatic do_read(input logic [6:0] a, input int mode, input bit inject);
        logic [31:0] exp_d;
        int          tc;
        int          n;
        int          stall_left;
        int          viol0;
        clear_q();
        viol0    = stall_viol;
        tx_ready = 1'b1;
        if (a >= NR) begin
            send({1'b0, a}, tc);
            idle(4);
            chk("bad_rd_err_n", err_q.size(), 1);
            if (err_q.size() > 0) chk("bad_rd_err_cyc", err_q[0], tc + 1);
            chk("bad_rd_txv", txv_q.size(), 0);
            chk("bad_rd_busy", busy, 0);
            return;
        end
        exp_d = ref_bank[a[3:0]];
        send({1'b0, a}, tc);
        stall_left = (mode == 2) ? 10 : 0;
        n = 0;
        while (ack_q.size() == 0 && n < 200) begin
            scr_req = 1'b0;
            if (mode == 1) begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end else if (mode == 2 && tx_q.size() == 1 && stall_left > 0) begin
                tx_ready = 1'b0;
                if (stall_left == 10) begin
                    scr_req  = 1'b1;
                    scr_addr = a[3:0];
                    scr_val  = ~exp_d;
                end
                if (stall_left == 3) chk("stall_hold", tx_data, exp_d[15:8]);
                stall_left--;
            end else begin
                tx_ready = 1'b1;
            end
            rx_valid = inject && (n == 0);
            rx_data  = 8'h55;
            tick();
            n++;
        end
        rx_valid = 1'b0;
        scr_req  = 1'b0;
        tx_ready = 1'b1;
        idle(2);
        chk("rd_in_time", n < 200, 1);
        chk("rd_nbytes", tx_q.size(), DB);
        for (int i = 0; i < tx_q.size() && i < DB; i++) chk("rd_byte", tx_q[i], exp_d[8*i +: 8]);
        chk("rd_first_valid", (txv_q.size() > 0) ? txv_q[0] : -1, tc + 2);
        chk("rd_ack_n", ack_q.size(), 1);
        if (ack_q.size() > 0 && tx_cyc_q.size() == DB) chk("rd_ack_cyc", ack_q[0], tx_cyc_q[DB-1] + 1);
        chk("rd_err_n", err_q.size(), inject ? 1 : 0);
        if (inject && err_q.size() > 0) chk("rd_drop_err_cyc", err_q[0], tc + 2);
        chk("tx_stable", stall_viol - viol0, 0);
        chk("rd_idle", busy, 0);
        if (mode == 2) ref_bank[a[3:0]] = ~exp_d;
    endtask

    initial begin
        int tc;
        int n;
        int r;
        rx_valid  = 1'b0;
        rx_data   = '0;
        tx_ready  = 1'b1;
        scr_req   = 1'b0;
        scr_addr  = '0;
        scr_val   = '0;
        bank_init = 1'b1;
        reset     = 1'b1;
        for (int i = 0; i < NR; i++) ref_bank[i] = init_val(i);
        idle(3);
        chk("reset_outs", {tx_valid, tx_data, reg_addr, reg_write, reg_wdata, reg_write_byte,
                           reg_write_done, reg_read_ack, busy, err}, '0);
        bank_init = 1'b0;
        reset     = 1'b0;
        idle(2);

        do_write(7'd3, 32'h44332211, DB, 0, 1'b0);
        do_read(7'd5, 0, 1'b0);
        do_read(7'd5, 2, 1'b0);
        do_read(7'h20, 0, 1'b0);
        do_write(7'h20, $urandom, DB, 2, 1'b0);
        do_write(7'd1, {24'($urandom), 8'hAA}, 1, 0, 1'b0);
        do_read(7'd1, 0, 1'b0);
        do_read(7'd3, 0, 1'b1);
        do_write(7'd2, $urandom, DB, 0, 1'b1);
        do_read(7'd2, 0, 1'b0);

        // Reset in the middle of a read aborts it with no acknowledge.
        clear_q();
        tx_ready = 1'b1;
        send(8'h07, tc);
        n = 0;
        while (tx_q.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("rst_pre_bytes", tx_q.size(), 2);
        tx_ready = 1'b0;
        reset    = 1'b1;
        tick();
        chk("rst_mid_outs", {tx_valid, tx_data, reg_addr, reg_write, reg_wdata, reg_write_byte,
                             reg_write_done, reg_read_ack, busy, err}, '0);
        reset    = 1'b0;
        tx_ready = 1'b1;
        idle(5);
        chk("rst_no_ack", ack_q.size(), 0);
        chk("rst_no_more_tx", tx_q.size(), 2);
        do_read(7'd7, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: do_write(7'($urandom_range(0, NR - 1)), $urandom, DB, 5, 1'b0);
                3:       do_write(7'($urandom_range(NR, 127)), $urandom, DB, 5, 1'b0);
                4, 5:    do_read(7'($urandom_range(0, NR - 1)), 1, 1'b0);
                6:       do_read(7'($urandom_range(0, NR - 1)), 1, 1'b1);
                7:       do_read(7'($urandom_range(NR, 127)), 0, 1'b0);
                8:       do_write(7'($urandom_range(0, NR - 1)), $urandom, $urandom_range(0, DB - 1), 5, 1'b0);
                default: begin
                    n = $urandom_range(0, NR - 1);
                    do_write(7'(n), $urandom, DB, 3, 1'b1);
                    do_read(7'(n), 1, 1'b0);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
- Byte-serial command sequencer between the PC monitor link and the register bank.
- Decodes command bytes arriving from the UART receiver.
- Write commands: drives byte-wise write strobes into the addressed register.
- Read commands: snapshots the addressed register and streams it back byte by byte to the UART transmitter, then acknowledges the read.
- One transaction at a time; a watchdog aborts stalled write frames.

Parameters:
- DATA_BYTES, 4: bytes per register; must be >= 2.
- NUM_REGS, 16: number of registers; addresses 0..NUM_REGS-1 are valid; must be <= 128.
- ADDR_W, 7: width of reg_addr; bits 6:0 of the command byte.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between bytes of one write frame.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle pulse; rx_data valid
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter can accept a byte
- tx_valid  out  1  tx_data valid; held until accepted
- tx_data  out  8  byte to transmit
- reg_addr  out  ADDR_W  target register select; bank muxes reg_rdata and steers strobes
- reg_write  out  1  one-cycle byte write strobe
- reg_wdata  out  8  byte to write
- reg_write_byte  out  $clog2(DATA_BYTES)  byte index of current strobe, 0 = LSB
- reg_write_done  out  1  one-cycle pulse after the last byte of a write
- reg_read_ack  out  1  one-cycle pulse after the last read byte is accepted
- reg_rdata  in  8*DATA_BYTES  data of the register selected by reg_addr
- busy  out  1  high whenever the FSM is not IDLE
- err  out  1  one-cycle pulse on bad address or timeout

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0.
- Reset mid-transaction aborts immediately. No write_done or read_ack is issued for the aborted transaction.
- Command byte format: bit7 = 1 for write, 0 for read; bits 6:0 = address.
- IDLE: on rx_valid, latch reg_addr <= rx_data[6:0] and clear the byte counter.
  - Write command -> WR_DATA.
  - Read, address valid -> RD_LOAD.
  - Read, address >= NUM_REGS -> pulse err next cycle and stay in IDLE; no bytes are sent.
- WR_DATA: each rx_valid produces, in the following cycle:
  - reg_write = 1, reg_wdata = byte, reg_write_byte = counter.
  - The counter then increments.
  - Bytes arrive LSB first.
  - After byte DATA_BYTES-1 is strobed -> WR_DONE.
  - Invalid address: bytes are consumed and counted but reg_write stays 0. In WR_DONE, err pulses instead of reg_write_done.
- WR_DONE: one cycle; reg_write_done = 1 -> IDLE.
- Watchdog:
  - Counts cycles in WR_DATA since the last rx_valid; cleared on every rx_valid.
  - On reaching TIMEOUT_CYCLES-1: pulse err, return to IDLE, no reg_write_done.
  - Bytes already strobed are not rolled back.
- RD_LOAD: one cycle; snapshot shift register <= reg_rdata -> RD_SEND.
  - The snapshot isolates the transfer from later register changes.
- RD_SEND:
  - tx_valid = 1, tx_data = snapshot[7:0].
  - On tx_valid && tx_ready: shift snapshot right by 8 and increment the counter.
  - After byte DATA_BYTES-1 is accepted -> RD_ACK.
  - tx_data is stable while tx_valid && !tx_ready.
- RD_ACK: one cycle; reg_read_ack = 1 -> IDLE.
- Latency:
  - Command byte at cycle N: first tx_valid at N+2 when tx_ready is held high.
  - Write byte at cycle N: reg_write at N+1.
- rx_valid received in RD_LOAD, RD_SEND, RD_ACK or WR_DONE is dropped and pulses err.
- rx_valid in IDLE on the same cycle as reg_write_done is accepted normally.
- Byte counter width is $clog2(DATA_BYTES). It wraps to 0 at the end of each frame and never indexes out of range.

Decomposition:
- Package reg_access_pkg holds:
  - FSM state enum: IDLE, WR_DATA, WR_DONE, RD_LOAD, RD_SEND, RD_ACK.
  - CMD_WRITE_BIT = 7 and the command field widths.
- Sub-module reg_access_timeout: loadable down-counter watchdog with clear and expire outputs; parameterized by TIMEOUT_CYCLES.

Test Plan:
- Write: send 0x83, 0x11, 0x22, 0x33, 0x44.
  - Four reg_write strobes with reg_addr = 3, byte indices 0..3 and data 0x11..0x44.
  - Then reg_write_done for one cycle; err never asserted.
- Read with reg_rdata = 0xDEADBEEF, address 5, tx_ready always 1: send 0x05.
  - tx_data sequence EF, BE, AD, DE starting 2 cycles after the command.
  - Then reg_read_ack for one cycle.
- Read backpressure: tx_ready low for 10 cycles in the middle of byte 1, and reg_rdata changes during the transfer.
  - tx_data holds 0xBE while stalled.
  - Transmitted bytes match the snapshot, not the new reg_rdata.
- Bad address (NUM_REGS = 16):
  - Read 0x20 -> err pulse, no tx_valid.
  - Write 0xA0 plus 4 bytes -> no reg_write strobes, err pulse at the end.
- Timeout (TIMEOUT_CYCLES = 50): send 0x81, 0xAA, then silence.
  - One reg_write, then err 50 cycles later, FSM back in IDLE.
  - A following read 0x01 completes normally.
- Reset mid-read after 2 of 4 bytes accepted: assert reset.
  - All outputs 0 next cycle, no reg_read_ack.
  - A new command is processed correctly after reset is released.
